// File: rtl/palette_pkg.sv
// palette_pkg: shared definitions for the palette lookup table.
//   R_W_DEF/G_W_DEF/B_W_DEF : default RGB565 channel widths
//   state_t                 : sequencer states (table load, normal run)
//   gray_level()            : value of entry k of an n-entry linear gray ramp
//                             for a w-bit channel, floor(k*(2**w-1)/(n-1))
package palette_pkg;

    localparam int R_W_DEF = 5;
    localparam int G_W_DEF = 6;
    localparam int B_W_DEF = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int gray_level(input int k, input int n, input int w);
        int max_v;
        int res;
        max_v = (1 << w) - 1;
        if (n < 2) begin
            res = 0;
        end else begin
            res = (k * max_v) / (n - 1);
        end
        return res;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// palette_ram: N-deep register-array colour table.
//   i_clk      : clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : entry to write
//   i_wr_data  : packed {red,green,blue} entry
//   i_rd_en    : read strobe; o_rd_data holds when low
//   i_rd_addr  : entry to read
//   o_rd_data  : registered read data, write-first on address collision
module palette_ram #(
    parameter int IDX_W = 2,
    parameter int D_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [D_W-1:0]   i_wr_data,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [D_W-1:0]   o_rd_data
);

    localparam int N = 1 << IDX_W;

    logic [D_W-1:0] mem [N];

    // The table contents need no reset: the top reloads every entry after reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            // Bypass so a same-edge write to the read address returns new data.
            if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
                o_rd_data <= i_wr_data;
            end else begin
                o_rd_data <= mem[i_rd_addr];
            end
        end
    end

endmodule

// File: rtl/palette_lut.sv
// palette_lut: programmable colour lookup table, pixel index -> RGB colour.
// After reset the table loads a linear gray ramp (one entry per cycle) while
// o_busy is high; afterwards entries can be rewritten at run time.
// Pixel path: index sampled at edge T, table read into stage 1, colour
// registered at edge T+1.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_data : table write port ({red,green,blue})
//   i_pix_valid/i_color       : pixel index input
//   i_dim                     : (PALETTE_DIM_EN only) halve this pixel's channels
//   o_busy                    : high while the default table is loading
//   o_pix_valid/o_red/o_green/o_blue : colour output, held while not valid
// Optional build macro: PALETTE_DIM_EN adds the i_dim input.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | writing gray ramp entry init_cnt; writes and pixels ignored
// ST_RUN  | normal operation; only reset leaves this state
module palette_lut
    import palette_pkg::*;
#(
    parameter int IDX_W = 2,
    parameter int R_W   = R_W_DEF,
    parameter int G_W   = G_W_DEF,
    parameter int B_W   = B_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [IDX_W-1:0]       i_wr_addr,
    input  logic [R_W+G_W+B_W-1:0] i_wr_data,
    input  logic                   i_pix_valid,
    input  logic [IDX_W-1:0]       i_color,
`ifdef PALETTE_DIM_EN
    input  logic                   i_dim,
`endif
    output logic                   o_busy,
    output logic                   o_pix_valid,
    output logic [R_W-1:0]         o_red,
    output logic [G_W-1:0]         o_green,
    output logic [B_W-1:0]         o_blue
);

    localparam int N   = 1 << IDX_W;
    localparam int D_W = R_W + G_W + B_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state;
    logic [IDX_W-1:0] init_cnt;
    logic             pv1;
    logic [D_W-1:0]   ramp_word;
    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [D_W-1:0]   ram_wdata;
    logic             pix_accept;
    logic [D_W-1:0]   rd_data;
    logic [R_W-1:0]   col_r;
    logic [G_W-1:0]   col_g;
    logic [B_W-1:0]   col_b;

    // Ramp values are constants per index, so this folds to a small mux.
    always_comb begin
        ramp_word = '0;
        for (int k = 0; k < N; k++) begin
            if (init_cnt == IDX_W'(k)) begin
                ramp_word = {R_W'(gray_level(k, N, R_W)),
                             G_W'(gray_level(k, N, G_W)),
                             B_W'(gray_level(k, N, B_W))};
            end
        end
    end

    // The loader owns the write port during INIT; user writes are dropped.
    assign ram_we     = (state == ST_INIT) ? 1'b1      : i_wr_en;
    assign ram_waddr  = (state == ST_INIT) ? init_cnt  : i_wr_addr;
    assign ram_wdata  = (state == ST_INIT) ? ramp_word : i_wr_data;
    assign pix_accept = (state == ST_RUN) && i_pix_valid;

    palette_ram #(
        .IDX_W (IDX_W),
        .D_W   (D_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (ram_we),
        .i_wr_addr (ram_waddr),
        .i_wr_data (ram_wdata),
        .i_rd_en   (pix_accept),
        .i_rd_addr (i_color),
        .o_rd_data (rd_data)
    );

`ifdef PALETTE_DIM_EN
    logic dim1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dim1 <= 1'b0;
        end else if (pix_accept) begin
            dim1 <= i_dim;
        end
    end

    always_comb begin
        col_r = rd_data[D_W-1 -: R_W];
        col_g = rd_data[B_W +: G_W];
        col_b = rd_data[B_W-1:0];
        if (dim1) begin
            col_r = col_r >> 1;
            col_g = col_g >> 1;
            col_b = col_b >> 1;
        end
    end
`else
    always_comb begin
        col_r = rd_data[D_W-1 -: R_W];
        col_g = rd_data[B_W +: G_W];
        col_b = rd_data[B_W-1:0];
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            o_busy      <= 1'b1;
            pv1         <= 1'b0;
            o_pix_valid <= 1'b0;
            o_red       <= '0;
            o_green     <= '0;
            o_blue      <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == LAST_IDX) begin
                        state  <= ST_RUN;
                        o_busy <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase

            pv1         <= pix_accept;
            o_pix_valid <= pv1;
            if (pv1) begin
                o_red   <= col_r;
                o_green <= col_g;
                o_blue  <= col_b;
            end
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: directed self-checking bench for palette_lut (IDX_W=2, RGB565).
module tb_palette_lut;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        pix_valid;
    logic [1:0]  color;
`ifdef PALETTE_DIM_EN
    logic        dim;
    logic        dim_q [8];
`endif
    logic        busy;
    logic        out_valid;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;

    int errors = 0;
    int checks = 0;

    logic [1:0]  idx_q [8];
    logic [15:0] exp_q [8];

    palette_lut #(.IDX_W(2), .R_W(5), .G_W(6), .B_W(5)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_pix_valid (pix_valid),
        .i_color     (color),
`ifdef PALETTE_DIM_EN
        .i_dim       (dim),
`endif
        .o_busy      (busy),
        .o_pix_valid (out_valid),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] rgb(input int r, input int g, input int b);
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; drives n pixels back to back and checks each
    // result at the negedge after the following posedge.
    task automatic run_stream(input string tag, input int n);
        for (int s = 0; s <= n; s++) begin
            if (s < n) begin
                pix_valid = 1'b1;
                color     = idx_q[s];
`ifdef PALETTE_DIM_EN
                dim       = dim_q[s];
`endif
            end else begin
                pix_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (s >= 1) begin
                chk({tag, "_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp_q[s-1]));
            end
        end
    endtask

    task automatic wait_init(input string tag);
        int  cyc;
        bit  saw;
        cyc = 0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (out_valid) saw = 1'b1;
            if (!busy) break;
        end
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'd4);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_no_valid"}, 32'(saw), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        pix_valid = 1'b0;
        color     = '0;
`ifdef PALETTE_DIM_EN
        dim       = 1'b0;
        for (int i = 0; i < 8; i++) dim_q[i] = 1'b0;
`endif
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);

        // Release reset with a write and a pixel held during the load.
        rst       = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 2'd2;
        wr_data   = rgb(1, 1, 1);
        pix_valid = 1'b1;
        color     = 2'd3;
        wait_init("init");
        wr_en     = 1'b0;
        pix_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("init_pixel_dropped", 32'(out_valid), 32'd0);
        end

        // Gray ramp readback; index 2 must be untouched by the INIT write.
        idx_q[0] = 2'd0; exp_q[0] = rgb(0, 0, 0);
        idx_q[1] = 2'd1; exp_q[1] = rgb(10, 21, 10);
        idx_q[2] = 2'd2; exp_q[2] = rgb(20, 42, 20);
        idx_q[3] = 2'd3; exp_q[3] = rgb(31, 63, 31);
        run_stream("ramp", 4);
        @(posedge clk);
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_rgb", 32'({red, green, blue}), 32'(rgb(31, 63, 31)));

        // Run-time write then back-to-back stream.
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = rgb(23, 48, 23);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        idx_q[0] = 2'd2; exp_q[0] = rgb(23, 48, 23);
        idx_q[1] = 2'd2; exp_q[1] = rgb(23, 48, 23);
        idx_q[2] = 2'd0; exp_q[2] = rgb(0, 0, 0);
        run_stream("wr2", 3);

        // Same-edge write and read of index 1: new data expected.
        wr_en     = 1'b1;
        wr_addr   = 2'd1;
        wr_data   = rgb(15, 34, 19);
        pix_valid = 1'b1;
        color     = 2'd1;
        @(posedge clk);
        @(negedge clk);
        wr_en     = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bypass_valid", 32'(out_valid), 32'd1);
        chk("bypass_rgb", 32'({red, green, blue}), 32'(rgb(15, 34, 19)));
        idx_q[0] = 2'd1; exp_q[0] = rgb(15, 34, 19);
        run_stream("bypass_stored", 1);

        // Consecutive writes to one address: the last one wins.
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = rgb(9, 9, 9);
        @(posedge clk);
        @(negedge clk);
        wr_data = rgb(5, 6, 7);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        idx_q[0] = 2'd0; exp_q[0] = rgb(5, 6, 7);
        run_stream("last_wins", 1);

        // Reset while pixels are in flight.
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1;
            color     = 2'(i);
            @(posedge clk);
            @(negedge clk);
        end
        rst       = 1'b1;
        pix_valid = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_rgb", 32'({red, green, blue}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");
        idx_q[0] = 2'd2; exp_q[0] = rgb(20, 42, 20);
        idx_q[1] = 2'd1; exp_q[1] = rgb(10, 21, 10);
        idx_q[2] = 2'd0; exp_q[2] = rgb(0, 0, 0);
        run_stream("reinit_ramp", 3);

`ifdef PALETTE_DIM_EN
        idx_q[0] = 2'd3; dim_q[0] = 1'b1; exp_q[0] = rgb(15, 31, 15);
        idx_q[1] = 2'd3; dim_q[1] = 1'b0; exp_q[1] = rgb(31, 63, 31);
        idx_q[2] = 2'd2; dim_q[2] = 1'b1; exp_q[2] = rgb(10, 21, 10);
        run_stream("dim", 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
Programmable colour lookup table that maps an IDX_W-bit pixel index to a RGB565-style colour (channel widths parametrised). It sits between the frame/pixel source and the display driver, replacing the fixed 4-entry palette. Entries are writable at run time. After reset the table self-loads a linear gray ramp. Pixel path is a 2-stage pipeline with a valid strobe.

Parameters:
IDX_W, 2, index width; table depth N = 2**IDX_W (legal range 1..8)
R_W, 5, red channel width
G_W, 6, green channel width
B_W, 5, blue channel width

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst  in  1  asynchronous, active-high reset
i_wr_en  in  1  palette write strobe
i_wr_addr  in  IDX_W  entry to write
i_wr_data  in  R_W+G_W+B_W  {red,green,blue}, red in MSBs
i_pix_valid  in  1  pixel index valid
i_color  in  IDX_W  pixel colour index
o_busy  out  1  high while the default table is loading
o_pix_valid  out  1  output colour valid
o_red  out  R_W  red
o_green  out  G_W  green
o_blue  out  B_W  blue

Behaviour:
- Reset is asynchronous and active-high: i_rst asserted forces o_busy=1, o_pix_valid=0, o_red/o_green/o_blue=0, both pipeline valid bits=0, FSM=INIT, init counter=0.
- FSM INIT: one entry per cycle, entry k <- gray ramp, per channel floor(k*(2**W-1)/(N-1)); N=2 gives 0 and max. After entry N-1 is written -> RUN; o_busy drops in the same cycle RUN is entered. INIT lasts exactly N cycles after reset release.
- In INIT: i_wr_en and i_pix_valid are ignored (no write, no valid issued).
- RUN: i_wr_en writes i_wr_data to i_wr_addr on the clock edge. RUN never returns to INIT except via reset.
- Pixel path latency is 2 cycles: i_pix_valid/i_color sampled at edge T -> stage-1 table read -> output registers load at T+1, so o_pix_valid and colour are visible after edge T+1. Back-to-back pixels give back-to-back outputs. No backpressure.
- Outputs hold their last value while o_pix_valid=0 (no zeroing between pixels).
- Write/read collision: a write and a pixel read to the same address at the same edge return the NEW data (write-first bypass).
- Writes to one address in consecutive cycles: the last one wins.
- Reset asserted mid-stream: pipeline flushed immediately, in-flight pixels are lost, and the table is re-initialised to the ramp. Any user-written entries are overwritten.

Optional Feature:
Macro PALETTE_DIM_EN. When it is defined, an extra input port i_dim (1 bit) exists. It is sampled alongside i_pix_valid and pipelined with the pixel. A pixel with i_dim=1 outputs each channel logically shifted right by 1 (half brightness, e.g. 31->15, 63->31). When the macro is undefined, the port is absent and colours always pass unmodified.

Decomposition:
- Package palette_pkg: default channel widths (R_W_DEF=5, G_W_DEF=6, B_W_DEF=5), FSM state enum {ST_INIT, ST_RUN}, and function gray_level(k, n, w) computing the ramp value.
- One sub-module, palette_ram: N-deep, R_W+G_W+B_W-wide register-array table. Synchronous write port, synchronous read port with write-first bypass. The top holds the FSM, init counter, valid pipeline and dim logic.

Test Plan:
- Reset release, IDX_W=2: o_busy high for exactly 4 cycles. Then indices 0,1,2,3 read back as red 0/10/20/31, green 0/21/42/63, blue 0/10/20/31.
- Pixel during INIT with i_pix_valid=1: no o_pix_valid ever asserted for it. A write during INIT does not alter the ramp.
- RUN, write addr 2 = {23,48,23}, then stream indices 2,2,0 on consecutive cycles: three consecutive valid outputs 2 cycles later, giving {23,48,23},{23,48,23},{0,0,0}.
- Same-edge write addr 1 = {15,34,19} and pixel read of index 1: output {15,34,19}, not the old ramp value.
- i_rst pulsed while 3 pixels are in flight: o_pix_valid=0 and colours=0 immediately. Previously written addr 2 reads the ramp value {20,42,20} after re-init.
- With PALETTE_DIM_EN defined, index 3 with i_dim=1: output {15,31,15}. With i_dim=0: output {31,63,31}.
